// File: rtl/reg_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_wb_pkg
// Brief    : Shared widths and load FSM state type for the writeback arbiter.
// Revision : 1.0
// ============================================================================
package reg_wb_pkg;

  localparam int REG_AW  = 4;
  localparam int DATA_W  = 16;
  localparam int NUM_REG = 16;
  localparam int ENTRY_W = REG_AW + DATA_W;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_RESP = 1'b1
  } ld_state_t;

endpackage
`default_nettype wire

// File: rtl/reg_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : reg_wb_fifo
// Brief    : Power-of-two depth FIFO holding {rd,data} ALU results in order.
// Revision : 1.0
// ============================================================================
module reg_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int              c_PTR_W   = $clog2(DEPTH);
  localparam logic [c_PTR_W:0] c_PTR_ONE = (c_PTR_W + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_PTR_W:0] r_wr_ptr;
  logic [c_PTR_W:0] r_rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                 (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
  assign head  = r_mem[r_rd_ptr[c_PTR_W-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (push) r_mem[r_wr_ptr[c_PTR_W-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/reg_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback_arbiter
// Brief    : Single-port register writeback arbiter between ALU results and one
//            outstanding load; optional WB_BYPASS_EN exposes the next write.
// Revision : 1.0
// ============================================================================
module reg_writeback_arbiter
  import reg_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               alu_valid,
  output logic               alu_ready,
  input  logic [REG_AW-1:0]  alu_rd,
  input  logic [DATA_W-1:0]  alu_data,
  input  logic               ld_issue_valid,
  output logic               ld_issue_ready,
  input  logic [REG_AW-1:0]  ld_issue_rd,
  input  logic               ld_resp_valid,
  input  logic [DATA_W-1:0]  ld_resp_data,
  output logic               write,
  output logic [REG_AW-1:0]  rd,
  output logic [DATA_W-1:0]  writedata,
`ifdef WB_BYPASS_EN
  output logic               byp_valid,
  output logic [REG_AW-1:0]  byp_rd,
  output logic [DATA_W-1:0]  byp_data,
`endif
  output logic [NUM_REG-1:0] busy
);

  ld_state_t          r_state;
  logic [REG_AW-1:0]  r_ld_rd;
  logic               r_kill;
  logic [NUM_REG-1:0] r_busy;
  logic               r_write;
  logic [REG_AW-1:0]  r_rd;
  logic [DATA_W-1:0]  r_wdata;

  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic               w_fifo_push;
  logic               w_fifo_pop;
  logic [ENTRY_W-1:0] w_fifo_head;
  logic               w_alu_live;
  logic               w_resp_fire;
  logic               w_resp_write;
  logic               w_kill_hit;
  logic               w_sel_valid;
  logic [REG_AW-1:0]  w_sel_rd;
  logic [DATA_W-1:0]  w_sel_data;

  assign alu_ready      = !w_fifo_full;
  assign ld_issue_ready = (r_state == IDLE);

  // rd 0 results are accepted but never written or buffered.
  assign w_alu_live   = alu_valid && alu_ready && (alu_rd != '0);
  assign w_resp_fire  = (r_state == WAIT_RESP) && ld_resp_valid;
  assign w_resp_write = w_resp_fire && !r_kill && (r_ld_rd != '0);
  assign w_kill_hit   = (r_state == WAIT_RESP) && w_alu_live && (alu_rd == r_ld_rd);
  assign w_fifo_pop   = !w_resp_write && !w_fifo_empty;
  assign w_fifo_push  = w_alu_live && (!w_fifo_empty || w_resp_fire);

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_rd    = '0;
    w_sel_data  = '0;
    if (w_resp_write) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = r_ld_rd;
      w_sel_data  = ld_resp_data;
    end else if (!w_fifo_empty) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = w_fifo_head[ENTRY_W-1:DATA_W];
      w_sel_data  = w_fifo_head[DATA_W-1:0];
    end else if (w_alu_live && !w_resp_fire) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = alu_rd;
      w_sel_data  = alu_data;
    end
  end

  reg_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_fifo_push),
    .push_data ({alu_rd, alu_data}),
    .pop       (w_fifo_pop),
    .head      (w_fifo_head),
    .empty     (w_fifo_empty),
    .full      (w_fifo_full)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_write <= 1'b0;
      r_rd    <= '0;
      r_wdata <= '0;
    end else begin
      r_write <= w_sel_valid;
      r_rd    <= w_sel_rd;
      r_wdata <= w_sel_data;
    end
  end

  // A younger ALU write to the pending register kills the load's write.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_ld_rd <= '0;
      r_kill  <= 1'b0;
      r_busy  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ld_issue_valid) begin
            r_state <= WAIT_RESP;
            r_ld_rd <= ld_issue_rd;
            r_kill  <= 1'b0;
            r_busy  <= '0;
            r_busy[ld_issue_rd] <= (ld_issue_rd != '0);
          end
        end
        WAIT_RESP: begin
          if (ld_resp_valid) begin
            r_state <= IDLE;
            r_kill  <= 1'b0;
            r_busy  <= '0;
          end else if (w_kill_hit) begin
            r_kill  <= 1'b1;
            r_busy  <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign write     = r_write;
  assign rd        = r_rd;
  assign writedata = r_wdata;
  assign busy      = r_busy;

`ifdef WB_BYPASS_EN
  assign byp_valid = w_sel_valid;
  assign byp_rd    = w_sel_rd;
  assign byp_data  = w_sel_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_writeback_arbiter
// Brief    : Directed scenarios plus random traffic against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_reg_writeback_arbiter;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [3:0]  alu_rd;
  logic [15:0] alu_data;
  logic        ld_issue_valid, ld_issue_ready;
  logic [3:0]  ld_issue_rd;
  logic        ld_resp_valid;
  logic [15:0] ld_resp_data;
  logic        write;
  logic [3:0]  rd;
  logic [15:0] writedata;
  logic [15:0] busy;
`ifdef WB_BYPASS_EN
  logic        byp_valid;
  logic [3:0]  byp_rd;
  logic [15:0] byp_data;
`endif

  always #5 clock = ~clock;

  reg_writeback_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .ld_issue_valid (ld_issue_valid),
    .ld_issue_ready (ld_issue_ready),
    .ld_issue_rd    (ld_issue_rd),
    .ld_resp_valid  (ld_resp_valid),
    .ld_resp_data   (ld_resp_data),
    .write          (write),
    .rd             (rd),
    .writedata      (writedata),
`ifdef WB_BYPASS_EN
    .byp_valid      (byp_valid),
    .byp_rd         (byp_rd),
    .byp_data       (byp_data),
`endif
    .busy           (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  rd;
    logic [15:0] data;
  } ent_t;

  // Model: ordered queue of buffered ALU results plus one outstanding load.
  ent_t       m_q[$];
  bit         m_pend = 1'b0;
  bit         m_kill = 1'b0;
  logic [3:0] m_ld_rd = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_busy();
    logic [15:0] b;
    b = '0;
    if (m_pend && !m_kill && m_ld_rd != 4'd0) b[m_ld_rd] = 1'b1;
    return b;
  endfunction

  task automatic step(input bit rs, input bit av, input logic [3:0] ard, input logic [15:0] adat,
                      input bit iv, input logic [3:0] ird, input bit rv, input logic [15:0] rdat);
    bit         acc, resp, rw, had, ew;
    logic [3:0] erd;
    logic [15:0] edat;
    ent_t       e;
    reset = rs; alu_valid = av; alu_rd = ard; alu_data = adat;
    ld_issue_valid = iv; ld_issue_rd = ird; ld_resp_valid = rv; ld_resp_data = rdat;
    #1;
    if (!rs) begin
      check("alu_ready", alu_ready, (m_q.size() < DEPTH));
      check("ld_issue_ready", ld_issue_ready, !m_pend);
    end
    ew = 0; erd = '0; edat = '0; acc = 0;
    if (rs) begin
      m_q.delete(); m_pend = 0; m_kill = 0; m_ld_rd = '0;
    end else begin
      acc  = av && (m_q.size() < DEPTH);
      resp = m_pend && rv;
      rw   = resp && !m_kill && (m_ld_rd != 0);
      had  = (m_q.size() != 0);
      if (rw) begin
        ew = 1; erd = m_ld_rd; edat = rdat;
      end else if (had) begin
        e = m_q.pop_front(); ew = 1; erd = e.rd; edat = e.data;
      end else if (acc && ard != 0 && !resp) begin
        ew = 1; erd = ard; edat = adat;
      end
      if (acc && ard != 0 && (had || resp)) begin
        e.rd = ard; e.data = adat; m_q.push_back(e);
      end
      if (!m_pend) begin
        if (iv) begin m_pend = 1; m_ld_rd = ird; m_kill = 0; end
      end else if (rv) begin
        m_pend = 0; m_kill = 0;
      end else if (acc && ard != 0 && ard == m_ld_rd) begin
        m_kill = 1;
      end
    end
`ifdef WB_BYPASS_EN
    if (!rs) begin
      check("byp_valid", byp_valid, ew);
      if (ew) check("byp_word", {byp_rd, byp_data}, {erd, edat});
    end
`endif
    @(posedge clock); #1;
    check("write", write, ew);
    if (ew) begin
      check("rd", rd, erd);
      check("writedata", writedata, edat);
    end
    check("busy", busy, exp_busy());
    @(negedge clock);
  endtask

  task automatic idle();
    step(0, 0, 4'd0, 16'h0, 0, 4'd0, 0, 16'h0);
  endtask

  task automatic do_reset();
    step(1, 0, 4'd0, 16'h0, 0, 4'd0, 0, 16'h0);
  endtask

  // Leaves FSM IDLE with FIFO holding two entries (rd3, rd5).
  task automatic fill_fifo();
    step(0, 0, 4'd0, 16'h0,    1, 4'd1, 0, 16'h0);
    step(0, 1, 4'd2, 16'hA000, 0, 4'd0, 1, 16'h1111);
    step(0, 1, 4'd3, 16'hB000, 1, 4'd4, 0, 16'h0);
    step(0, 1, 4'd5, 16'hC000, 0, 4'd0, 1, 16'h4444);
  endtask

  initial begin
    do_reset();
    check("rst_write", write, 1'b0);
    check("rst_rd", rd, 4'd0);
    check("rst_writedata", writedata, 16'h0);
    check("rst_busy", busy, 16'h0);
    check("rst_alu_ready", alu_ready, 1'b1);
    check("rst_ld_issue_ready", ld_issue_ready, 1'b1);

    // ALU only
    step(0, 1, 4'd3, 16'h1234, 0, 4'd0, 0, 16'h0);
    check("alu_only", {31'(write), 20'h0} | {rd, writedata}, {31'(1'b1), 20'h0} | {4'd3, 16'h1234});

    // Load response and ALU result in the same cycle
    step(0, 0, 4'd0, 16'h0, 1, 4'd5, 0, 16'h0);
    check("coll_busy", busy, 16'h0020);
    step(0, 1, 4'd6, 16'h0001, 0, 4'd0, 1, 16'hBEEF);
    check("coll_first", {write, rd, writedata}, {1'b1, 4'd5, 16'hBEEF});
    idle();
    check("coll_second", {write, rd, writedata}, {1'b1, 4'd6, 16'h0001});

    // Full FIFO backpressure; held result must survive
    do_reset();
    fill_fifo();
    check("full_not_ready", alu_ready, 1'b0);
    step(0, 1, 4'd6, 16'hD00D, 0, 4'd0, 0, 16'h0);
    check("drained_ready", alu_ready, 1'b1);
    step(0, 1, 4'd6, 16'hD00D, 0, 4'd0, 0, 16'h0);
    idle();
    check("held_result", {write, rd, writedata}, {1'b1, 4'd6, 16'hD00D});

    // Kill: younger ALU write to the pending load register
    do_reset();
    step(0, 0, 4'd0, 16'h0, 1, 4'd7, 0, 16'h0);
    check("kill_busy_set", busy, 16'h0080);
    step(0, 1, 4'd7, 16'h00AA, 0, 4'd0, 0, 16'h0);
    check("kill_alu_write", {write, rd, writedata}, {1'b1, 4'd7, 16'h00AA});
    check("kill_busy_clr", busy, 16'h0);
    step(0, 0, 4'd0, 16'h0, 0, 4'd0, 1, 16'h5555);
    check("kill_no_write", write, 1'b0);

    // Register 0 is never written
    do_reset();
    step(0, 1, 4'd0, 16'hFFFF, 0, 4'd0, 0, 16'h0);
    check("r0_alu", write, 1'b0);
    step(0, 0, 4'd0, 16'h0, 1, 4'd0, 0, 16'h0);
    check("r0_busy", busy, 16'h0);
    step(0, 0, 4'd0, 16'h0, 0, 4'd0, 1, 16'h7777);
    check("r0_load", write, 1'b0);

    // Reset in WAIT_RESP with two buffered entries
    do_reset();
    fill_fifo();
    step(0, 1, 4'd9, 16'hE000, 1, 4'd8, 0, 16'h0);
    check("pre_rst_busy", busy, 16'h0100);
    do_reset();
    check("rst_mid_busy", busy, 16'h0);
    check("rst_mid_issue_ready", ld_issue_ready, 1'b1);
    step(0, 0, 4'd0, 16'h0, 0, 4'd0, 1, 16'hDEAD);
    check("rst_mid_no_write", write, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 16'($urandom),
           ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 7)),
           ($urandom_range(0, 2) == 0), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
